// File: rtl/axi_master_bridge.sv
// axi_master_bridge: single-outstanding core request bus to AXI4 master bridge with INCR bursts up to 256x64b.
// Optional AXI_BRIDGE_RLAST_CHECK_EN ends reads on the beat counter and flags rlast mismatches in resp_err.
module axi_master_bridge #(
  parameter logic AXI_ID = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_len,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [63:0] wd_data,
  input  logic [7:0]  wd_strb,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  output logic        resp_last,
  output logic        resp_err,
  input  logic        io_master_awready,
  output logic        io_master_awvalid,
  output logic [31:0] io_master_awaddr,
  output logic        io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  output logic        io_master_awlock,
  output logic [3:0]  io_master_awcache,
  output logic [2:0]  io_master_awprot,
  output logic [3:0]  io_master_awqos,
  output logic        io_master_awuser,
  input  logic        io_master_wready,
  output logic        io_master_wvalid,
  output logic [63:0] io_master_wdata,
  output logic [7:0]  io_master_wstrb,
  output logic        io_master_wlast,
  output logic        io_master_bready,
  input  logic        io_master_bvalid,
  input  logic [1:0]  io_master_bresp,
  input  logic        io_master_bid,
  input  logic        io_master_buser,
  input  logic        io_master_arready,
  output logic        io_master_arvalid,
  output logic [31:0] io_master_araddr,
  output logic        io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  output logic        io_master_arlock,
  output logic [3:0]  io_master_arcache,
  output logic [2:0]  io_master_arprot,
  output logic [3:0]  io_master_arqos,
  output logic        io_master_aruser,
  output logic        io_master_rready,
  input  logic        io_master_rvalid,
  input  logic [1:0]  io_master_rresp,
  input  logic [63:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic        io_master_rid,
  input  logic        io_master_ruser
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  len_q, len_d, cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d, resp_last_q, resp_last_d, resp_err_q, resp_err_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic        last_beat;
  logic        unused_inputs;
`ifdef AXI_BRIDGE_RLAST_CHECK_EN
  logic        early_q, early_d;
`endif
  assign last_beat = cnt_q == len_q;
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_last_d  = resp_last_q;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
`ifdef AXI_BRIDGE_RLAST_CHECK_EN
    early_d      = early_q;
`endif
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        addr_d  = req_addr;
        size_d  = req_size;
        len_d   = req_len;
        cnt_d   = 8'd0;
`ifdef AXI_BRIDGE_RLAST_CHECK_EN
        early_d = 1'b0;
`endif
        state_d = req_is_write ? WR_ADDR : RD_ADDR;
      end
      RD_ADDR: state_d = io_master_arready ? RD_DATA : RD_ADDR;
      RD_DATA: if (io_master_rvalid) begin
        resp_valid_d = 1'b1;
        resp_data_d  = io_master_rdata;
        cnt_d        = cnt_q + 8'd1;
`ifdef AXI_BRIDGE_RLAST_CHECK_EN
        resp_last_d  = last_beat;
        resp_err_d   = io_master_rresp[1] | (last_beat & (early_q | ~io_master_rlast));
        early_d      = early_q | (io_master_rlast & ~last_beat);
        state_d      = last_beat ? IDLE : RD_DATA;
`else
        resp_last_d  = io_master_rlast;
        resp_err_d   = io_master_rresp[1];
        state_d      = io_master_rlast ? IDLE : RD_DATA;
`endif
      end
      WR_ADDR: state_d = io_master_awready ? WR_DATA : WR_ADDR;
      WR_DATA: if (wd_valid && io_master_wready) begin
        cnt_d   = cnt_q + 8'd1;
        state_d = last_beat ? WR_RESP : WR_DATA;
      end
      WR_RESP: if (io_master_bvalid) begin
        resp_valid_d = 1'b1;
        resp_last_d  = 1'b1;
        resp_err_d   = io_master_bresp[1];
        resp_data_d  = 64'd0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      size_q       <= 3'd0;
      len_q        <= 8'd0;
      cnt_q        <= 8'd0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 64'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end
`ifdef AXI_BRIDGE_RLAST_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) early_q <= 1'b0;
    else early_q <= early_d;
  end
`endif
  // Holding off req_ready during the final pulse keeps responses of consecutive transactions apart.
  assign req_ready         = state_q == IDLE && !resp_valid_q;
  assign resp_valid        = resp_valid_q;
  assign resp_data         = resp_data_q;
  assign resp_last         = resp_last_q;
  assign resp_err          = resp_err_q;
  assign io_master_awvalid = state_q == WR_ADDR;
  assign io_master_awaddr  = addr_q;
  assign io_master_awid    = AXI_ID;
  assign io_master_awlen   = len_q;
  assign io_master_awsize  = size_q;
  assign io_master_awburst = 2'b01;
  assign io_master_awlock  = 1'b0;
  assign io_master_awcache = 4'd0;
  assign io_master_awprot  = 3'd0;
  assign io_master_awqos   = 4'd0;
  assign io_master_awuser  = 1'b0;
  assign io_master_wvalid  = state_q == WR_DATA && wd_valid;
  assign wd_ready          = state_q == WR_DATA && io_master_wready;
  assign io_master_wdata   = wd_data;
  assign io_master_wstrb   = wd_strb;
  assign io_master_wlast   = state_q == WR_DATA && last_beat;
  assign io_master_bready  = state_q == WR_RESP;
  assign io_master_arvalid = state_q == RD_ADDR;
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = AXI_ID;
  assign io_master_arlen   = len_q;
  assign io_master_arsize  = size_q;
  assign io_master_arburst = 2'b01;
  assign io_master_arlock  = 1'b0;
  assign io_master_arcache = 4'd0;
  assign io_master_arprot  = 3'd0;
  assign io_master_arqos   = 4'd0;
  assign io_master_aruser  = 1'b0;
  assign io_master_rready  = state_q == RD_DATA;
  assign unused_inputs     = ^{io_master_bid, io_master_buser, io_master_rid, io_master_ruser,
                               io_master_bresp[0], io_master_rresp[0], io_master_rlast};
endmodule

// File: tb/tb_axi_master_bridge.sv
// tb_axi_master_bridge: directed-vector bench for axi_master_bridge, sampling between clock edges.
module tb_axi_master_bridge;
  logic        clock = 1'b0, reset;
  logic        req_valid, req_ready, req_is_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_len;
  logic        wd_valid, wd_ready;
  logic [63:0] wd_data;
  logic [7:0]  wd_strb;
  logic        resp_valid, resp_last, resp_err;
  logic [63:0] resp_data;
  logic        awready, awvalid, awid, awlock, awuser;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic [3:0]  awcache, awqos;
  logic        wready, wvalid, wlast;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bready, bvalid;
  logic [1:0]  bresp;
  logic        arready, arvalid, arid, arlock, aruser;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic [3:0]  arcache, arqos;
  logic        rready, rvalid, rlast;
  logic [1:0]  rresp;
  logic [63:0] rdata;
  int          vectors = 0, errors = 0;

  axi_master_bridge #(.AXI_ID(1'b0)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_size(req_size), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last), .resp_err(resp_err),
    .io_master_awready(awready), .io_master_awvalid(awvalid), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
    .io_master_awburst(awburst), .io_master_awlock(awlock), .io_master_awcache(awcache),
    .io_master_awprot(awprot), .io_master_awqos(awqos), .io_master_awuser(awuser),
    .io_master_wready(wready), .io_master_wvalid(wvalid), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
    .io_master_bid(1'b0), .io_master_buser(1'b0),
    .io_master_arready(arready), .io_master_arvalid(arvalid), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
    .io_master_arburst(arburst), .io_master_arlock(arlock), .io_master_arcache(arcache),
    .io_master_arprot(arprot), .io_master_arqos(arqos), .io_master_aruser(aruser),
    .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rresp(rresp),
    .io_master_rdata(rdata), .io_master_rlast(rlast),
    .io_master_rid(1'b0), .io_master_ruser(1'b0)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 0; req_is_write = 0; req_addr = 0; req_size = 0; req_len = 0;
    wd_valid = 0; wd_data = 0; wd_strb = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0; rlast = 0;
    tick; tick;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_last", resp_last, 0);
    chk("rst_resp_err", resp_err, 0);
    reset = 1'b0;
    tick;
    // single read
    req_valid = 1; req_is_write = 0; req_addr = 32'h8000_0000; req_size = 3; req_len = 0;
    #1;
    chk("rd1_req_ready", req_ready, 1);
    tick; req_valid = 0;
    chk("rd1_arvalid", arvalid, 1);
    chk("rd1_araddr", araddr, 64'h8000_0000);
    chk("rd1_arlen", arlen, 0);
    chk("rd1_arsize", arsize, 3);
    chk("rd1_arburst", arburst, 1);
    chk("rd1_arid", arid, 0);
    chk("rd1_req_busy", req_ready, 0);
    arready = 1;
    tick; arready = 0;
    chk("rd1_arvalid_drop", arvalid, 0);
    chk("rd1_rready", rready, 1);
    rvalid = 1; rdata = 64'h1122_3344_5566_7788; rresp = 0; rlast = 1;
    tick; rvalid = 0; rlast = 0;
    chk("rd1_resp_valid", resp_valid, 1);
    chk("rd1_resp_data", resp_data, 64'h1122_3344_5566_7788);
    chk("rd1_resp_last", resp_last, 1);
    chk("rd1_resp_err", resp_err, 0);
    chk("rd1_rready_off", rready, 0);
    chk("rd1_ready_pulse", req_ready, 0);
    tick;
    chk("rd1_resp_clear", resp_valid, 0);
    chk("rd1_ready_again", req_ready, 1);
    // burst read with gaps, DECERR on second beat
    req_valid = 1; req_addr = 32'h0000_1000; req_len = 7;
    tick; req_valid = 0;
    chk("rd8_arvalid", arvalid, 1);
    chk("rd8_arlen", arlen, 7);
    tick;
    chk("rd8_arvalid_hold", arvalid, 1);
    chk("rd8_araddr_hold", araddr, 64'h1000);
    arready = 1;
    tick; arready = 0;
    for (int i = 0; i < 8; i++) begin
      rvalid = 1; rdata = 64'hA5A5_0000_0000_0000 | 64'(i); rresp = (i == 1) ? 2'b11 : 2'b00; rlast = (i == 7);
      tick; rvalid = 0; rlast = 0; rresp = 0;
      chk("rd8_resp_valid", resp_valid, 1);
      chk("rd8_resp_data", resp_data, 64'hA5A5_0000_0000_0000 | 64'(i));
      chk("rd8_resp_last", resp_last, (i == 7) ? 1 : 0);
      chk("rd8_resp_err", resp_err, (i == 1) ? 1 : 0);
      if (i == 1 || i == 4) begin
        tick;
        chk("rd8_gap_resp", resp_valid, 0);
        chk("rd8_gap_rready", rready, 1);
      end
    end
    chk("rd8_ready_pulse", req_ready, 0);
    tick;
    chk("rd8_idle_ready", req_ready, 1);
    chk("rd8_idle_rready", rready, 0);
    // burst write with a wready stall on beat 2
    req_valid = 1; req_is_write = 1; req_addr = 32'h0000_2000; req_len = 3; req_size = 3;
    tick; req_valid = 0;
    wd_valid = 1; wd_data = 64'hD000; wd_strb = 8'hF0; wready = 1;
    #1;
    chk("wr4_awvalid", awvalid, 1);
    chk("wr4_awaddr", awaddr, 64'h2000);
    chk("wr4_awlen", awlen, 3);
    chk("wr4_awsize", awsize, 3);
    chk("wr4_awburst", awburst, 1);
    chk("wr4_no_wvalid", wvalid, 0);
    chk("wr4_no_wd_ready", wd_ready, 0);
    chk("wr4_no_bready", bready, 0);
    tick;
    chk("wr4_awvalid_hold", awvalid, 1);
    chk("wr4_no_wvalid2", wvalid, 0);
    awready = 1;
    #1;
    chk("wr4_no_wvalid_aw_hs", wvalid, 0);
    tick; awready = 0;
    chk("wr4_awvalid_drop", awvalid, 0);
    for (int i = 0; i < 4; i++) begin
      wd_data = 64'hD000 + 64'(i); wd_strb = 8'hF0 + 8'(i); wready = (i != 1);
      #1;
      if (i == 1) begin
        chk("wr4_stall_wvalid", wvalid, 1);
        chk("wr4_stall_wd_ready", wd_ready, 0);
        chk("wr4_stall_wlast", wlast, 0);
        tick; wready = 1;
        #1;
      end
      chk("wr4_wvalid", wvalid, 1);
      chk("wr4_wd_ready", wd_ready, 1);
      chk("wr4_wdata", wdata, 64'hD000 + 64'(i));
      chk("wr4_wstrb", wstrb, 8'hF0 + 8'(i));
      chk("wr4_wlast", wlast, (i == 3) ? 1 : 0);
      tick;
    end
    wd_valid = 0; wready = 0;
    chk("wr4_resp_wvalid", wvalid, 0);
    chk("wr4_bready", bready, 1);
    chk("wr4_no_early_resp", resp_valid, 0);
    bvalid = 1; bresp = 2'b00;
    tick; bvalid = 0;
    chk("wr4_resp_valid", resp_valid, 1);
    chk("wr4_resp_last", resp_last, 1);
    chk("wr4_resp_err", resp_err, 0);
    chk("wr4_resp_data", resp_data, 0);
    chk("wr4_bready_off", bready, 0);
    tick;
    chk("wr4_resp_clear", resp_valid, 0);
    chk("wr4_ready_again", req_ready, 1);
    // single write completing with SLVERR
    req_valid = 1; req_is_write = 1; req_addr = 32'h0000_3000; req_len = 0;
    tick; req_valid = 0; awready = 1;
    tick; awready = 0;
    wd_valid = 1; wready = 1; wd_data = 64'h55; wd_strb = 8'h01;
    #1;
    chk("wr1_wlast", wlast, 1);
    tick; wd_valid = 0; wready = 0;
    bvalid = 1; bresp = 2'b10;
    tick; bvalid = 0; bresp = 0;
    chk("wr1_resp_valid", resp_valid, 1);
    chk("wr1_resp_err", resp_err, 1);
    chk("wr1_resp_data", resp_data, 0);
    tick;
    // read len 3 with rlast raised early on beat 2
    req_valid = 1; req_is_write = 0; req_addr = 32'h0000_4000; req_len = 3;
    tick; req_valid = 0; arready = 1;
    tick; arready = 0;
`ifdef AXI_BRIDGE_RLAST_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = 64'hE0 + 64'(i); rlast = (i == 1);
      tick; rvalid = 0; rlast = 0;
      chk("early_resp_valid", resp_valid, 1);
      chk("early_resp_last", resp_last, (i == 3) ? 1 : 0);
      chk("early_resp_err", resp_err, (i == 3) ? 1 : 0);
    end
`else
    for (int i = 0; i < 2; i++) begin
      rvalid = 1; rdata = 64'hE0 + 64'(i); rlast = (i == 1);
      tick; rvalid = 0; rlast = 0;
      chk("early_resp_valid", resp_valid, 1);
      chk("early_resp_last", resp_last, (i == 1) ? 1 : 0);
      chk("early_resp_err", resp_err, 0);
    end
    chk("early_rready_off", rready, 0);
`endif
    tick;
    chk("early_ready_again", req_ready, 1);
    // reset asserted during beat 3 of an 8-beat read
    req_valid = 1; req_addr = 32'h0000_5000; req_len = 7;
    tick; req_valid = 0; arready = 1;
    tick; arready = 0;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1; rdata = 64'(i);
      tick; rvalid = 0;
    end
    chk("mid_rready_before", rready, 1);
    rvalid = 1; reset = 1;
    #1;
    chk("mid_arvalid", arvalid, 0);
    chk("mid_rready", rready, 0);
    chk("mid_awvalid", awvalid, 0);
    chk("mid_wvalid", wvalid, 0);
    chk("mid_bready", bready, 0);
    chk("mid_resp_valid", resp_valid, 0);
    tick; reset = 0; rvalid = 0;
    tick;
    chk("mid_req_ready", req_ready, 1);
    chk("mid_arvalid_after", arvalid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/axi_master_bridge.md
# axi_master_bridge

- Converts the core's internal memory request bus into AXI4 master transactions on the `io_master_*` port of `riscv_cpu_top`.
- Sits directly between the cache/memory-access logic inside `mycpu_top` and the top-level AXI4 pins, and owns all AW/W/B/AR/R handshaking.
- Handles one outstanding transaction at a time, read or write, with INCR bursts of up to 256 beats of 64 bits.

## Interface
Parameters:
- AXI_ID, 0, value driven on io_master_awid/io_master_arid (1 bit)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  bridge can accept a request (high only in IDLE)
- req_is_write  in  1  1 = write, 0 = read
- req_addr  in  32  start byte address
- req_size  in  3  AXI size code (0..3)
- req_len  in  8  beats minus one
- wd_valid / wd_ready  in / out  1 / 1  write-data beat handshake from core
- wd_data / wd_strb  in  64 / 8  write-data beat and byte strobes
- resp_valid  out  1  response pulse (one read beat, or write completion)
- resp_data  out  64  read beat data (0 for writes)
- resp_last  out  1  final response of the transaction
- resp_err  out  1  resp[1] of the beat or of B
- io_master_aw{ready,valid,addr,len,size,burst}, io_master_w{ready,valid,data,strb,last}, io_master_b{ready,valid,resp}: standard AXI4 write channels, widths as on riscv_cpu_top
- io_master_ar{ready,valid,addr,len,size,burst}, io_master_r{ready,valid,resp,data,last}: standard AXI4 read channels
- Constant outputs: io_master_awburst/arburst = 2'b01; prot/lock/cache/qos/user = 0; awid/arid = AXI_ID. Inputs bid/buser/rid/ruser are ignored.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, size and len, clear beat counter, and go to RD_ADDR or WR_ADDR per req_is_write.
- RD_ADDR:
  - arvalid=1 with the latched fields.
  - On arready, go to RD_DATA.
- RD_DATA:
  - rready=1.
  - Each R handshake registers rdata into resp_data, pulses resp_valid the next cycle, sets resp_err=rresp[1], and increments the beat counter.
  - The beat with rlast=1 also sets resp_last=1 and returns to IDLE.
- WR_ADDR:
  - awvalid=1.
  - On awready, go to WR_DATA. W is never driven before the AW handshake.
- WR_DATA: combinational pass-through.
  - wvalid = wd_valid.
  - wd_ready = wready.
  - wdata/wstrb = wd_data/wd_strb.
  - wlast = (beat counter == latched len).
  - Each W handshake increments the counter. The handshake with wlast=1 goes to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid, pulse resp_valid with resp_last=1, resp_err=bresp[1], resp_data=0, and return to IDLE.
- Beat counter is 8 bits and never wraps within a transaction (max len 255).
- The core must accept every resp_valid pulse; there is no response backpressure.

## Timing
- Reset (asynchronous, active-high) forces:
  - State to IDLE.
  - All AXI valid/ready outputs to 0.
  - resp_valid, resp_last and resp_err to 0, and resp_data to 0.
  - Counter to 0.
- Reset asserted mid-transaction abandons the transaction immediately. No cleanup beats are issued.
- Read path:
  - Request accepted in cycle N; arvalid is high from cycle N+1.
  - A read beat handshaken in cycle M appears on resp_* in cycle M+1.
- Write completion: B handshake in cycle M gives resp_valid in cycle M+1.
- AXI hold rules:
  - arvalid/awvalid, once high, stay high with stable fields until ready.
  - wvalid is never deasserted by the bridge itself; it follows wd_valid, and the core must hold wd_valid until wd_ready.
- Back-to-back: a new request can be accepted in the cycle after the final resp_valid pulse, so min 1 idle cycle between transactions.
- Simultaneous arvalid and arready in the first cycle is a legal single-cycle address phase.

## Configuration
- AXI_BRIDGE_RLAST_CHECK_EN:
  - Defined: the read path tracks the beat count against len and ends the read on the counter, not on rlast.
  - If rlast arrives early, or is missing on beat len, the final resp_valid has resp_err=1.
  - Any beat after an early rlast is still consumed.
- Undefined:
  - rlast alone terminates the read.
  - resp_err reflects only rresp[1].

## Test plan
- Single read:
  - Stimulus: addr 0x8000_0000, len 0, size 3; slave returns 0x1122334455667788 with OKAY.
  - Required: arvalid 1 cycle after accept, arlen=0; one resp_valid with that data, resp_last=1, resp_err=0.
- Burst read:
  - Stimulus: len 7; slave inserts rvalid gaps.
  - Required: 8 resp_valid pulses in order; resp_last only on the 8th; state back to IDLE.
- Burst write:
  - Stimulus: len 3; wready stalls on beat 2; bresp=OKAY.
  - Required: no wvalid before the AW handshake; wlast only on beat 4; one completion pulse with resp_err=0.
- Error responses:
  - Stimulus: bresp=SLVERR on a write; rresp=DECERR on beat 1 of a read.
  - Required: resp_err=1 on the corresponding pulse.
- Reset mid-transaction:
  - Stimulus: reset asserted during RD_DATA at beat 3 of 8.
  - Required: all valids 0 immediately; req_ready=1 after release.
- Macro defined:
  - Stimulus: len 3, slave raises rlast on beat 2.
  - Required: final pulse has resp_err=1.
